// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared register map constants and helpers for the interrupt controller
package int_ctrl_pkg;

    // Register select, taken from bus_addr[3:2]
    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_MASK    = 2'd1,
        REG_MODE    = 2'd2,
        REG_VECTOR  = 2'd3
    } reg_sel_e;

    // Window size and default base, also used by the bridge decoder
    localparam logic [31:0] INT_WIN_BYTES = 32'd16;
    localparam logic [31:0] INT_BASE_ADDR = 32'h0000_7f20;

    // Lowest-index set bit of req, returned as {valid, id[7:0]}
    function automatic logic [8:0] prio_encode(input logic [7:0] req);
        logic [8:0] res;
        res = 9'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                res = {1'b1, 8'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - register bus between the bridge (master) and the interrupt controller (slave)
// Signals: bus_addr/bus_byteen/bus_wdata from the bridge, bus_rdata/bus_hit back to it.
interface int_ctrl_if;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_hit;

    modport master (
        output bus_addr, bus_byteen, bus_wdata,
        input  bus_rdata, bus_hit
    );

    modport slave (
        input  bus_addr, bus_byteen, bus_wdata,
        output bus_rdata, bus_hit
    );
endinterface

// File: rtl/int_ctrl_src_latch.sv
// rtl/int_ctrl_src_latch.sv - per-source request latch (src_prev + PENDING bit)
// Ports: clk, reset (sync, active-high), src_i raw request, mode_i (1=edge, 0=level),
//        prev_clr_i clears src_prev on a mode change, w1c_i acknowledge, pend_o PENDING bit.
module int_src_latch (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    input  logic mode_i,
    input  logic prev_clr_i,
    input  logic w1c_i,
    output logic pend_o
);
    logic prev_q, prev_d;
    logic pend_q, pend_d;
    logic rise;

    always_comb begin
        rise   = src_i & ~prev_q;
        prev_d = prev_clr_i ? 1'b0 : src_i;
        // Edge: a new rise beats a same-cycle ack so no request is lost.
        // Level: the bit simply follows the source, overriding any ack.
        if (mode_i) begin
            pend_d = rise | (pend_q & ~w1c_i);
        end else begin
            pend_d = src_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - memory-mapped interrupt controller (PENDING/MASK/MODE/VECTOR) driving hw_int to CP0
// Ports: clk, reset (sync, active-high), src_in[N_SRC] raw requests, bus (int_ctrl_if.slave)
//        register window at BASE_ADDR, hw_int[N_SRC] registered PENDING & MASK.
// Option: INT_CTRL_PRIO_EN adds the VECTOR priority encoder and vector acknowledge.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                 N_SRC     = 6,
    parameter logic [31:0]        BASE_ADDR = INT_BASE_ADDR,
    parameter logic [N_SRC-1:0]   MASK_RST  = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    int_ctrl_if.slave        bus,
    output logic [N_SRC-1:0] hw_int
);
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] hw_int_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] w1c, prev_clr, wmask, wbits, vec_ack;
    logic [31:0]      win_off, lane32;
    logic             hit, wr;
    reg_sel_e         sel;

    // Unsigned offset compare covers both window edges in one test
    assign win_off = bus.bus_addr - BASE_ADDR;
    assign hit     = win_off < INT_WIN_BYTES;
    assign sel     = reg_sel_e'(bus.bus_addr[3:2]);
    assign wr      = hit & (|bus.bus_byteen);
    assign lane32  = {{8{bus.bus_byteen[3]}}, {8{bus.bus_byteen[2]}},
                      {8{bus.bus_byteen[1]}}, {8{bus.bus_byteen[0]}}};
    assign wmask   = lane32[N_SRC-1:0];
    assign wbits   = bus.bus_wdata[N_SRC-1:0] & wmask;

`ifdef INT_CTRL_PRIO_EN
    logic [8:0] vec_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_q <= 9'd0;
        end else begin
            vec_q <= prio_encode(8'(pending & mask_q));
        end
    end
    // Any-lane write to VECTOR acknowledges the currently reported id
    assign vec_ack = (wr && sel == REG_VECTOR && vec_q[8]) ? (N_SRC'(1) << vec_q[7:0]) : '0;
`else
    assign vec_ack = '0;
`endif

    always_comb begin
        mask_d   = mask_q;
        mode_d   = mode_q;
        w1c      = vec_ack;
        prev_clr = '0;
        if (wr) begin
            case (sel)
                REG_PENDING: w1c    = w1c | wbits;
                REG_MASK:    mask_d = (mask_q & ~wmask) | wbits;
                REG_MODE:    mode_d = (mode_q & ~wmask) | wbits;
                default:     ;
            endcase
        end
        prev_clr = mode_d ^ mode_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= MASK_RST;
            mode_q   <= '0;
            hw_int_q <= '0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            hw_int_q <= pending & mask_q;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        int_src_latch u_latch (
            .clk        (clk),
            .reset      (reset),
            .src_i      (src_in[i]),
            .mode_i     (mode_q[i]),
            .prev_clr_i (prev_clr[i]),
            .w1c_i      (w1c[i]),
            .pend_o     (pending[i])
        );
    end

    // Read path is combinational on current state, so a same-cycle write reads the old value
    always_comb begin
        bus.bus_rdata = '0;
        if (hit) begin
            case (sel)
                REG_PENDING: bus.bus_rdata = 32'(pending);
                REG_MASK:    bus.bus_rdata = 32'(mask_q);
                REG_MODE:    bus.bus_rdata = 32'(mode_q);
`ifdef INT_CTRL_PRIO_EN
                REG_VECTOR:  bus.bus_rdata = {vec_q[8], 23'd0, vec_q[7:0]};
`endif
                default:     bus.bus_rdata = '0;
            endcase
        end
    end

    assign bus.bus_hit = hit;
    assign hw_int      = hw_int_q;

    logic unused_ok;
    assign unused_ok = ^{bus.bus_wdata, lane32};
endmodule
